// File: rtl/test_engine_scheduler.sv
// Round-robin front end sharing one test_engine among NUM_PORTS requesters.
// Grants in IDLE, issues start, watches done under a watchdog, returns C/D.
module test_engine_scheduler #(
  parameter int NUM_PORTS  = 4,
  parameter int ROUNDS     = 16,
  parameter int WDOG_SLACK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    req_din,
  input  logic [64*NUM_PORTS-1:0] wordA_din,
  input  logic [64*NUM_PORTS-1:0] wordB_din,
  output logic [NUM_PORTS-1:0]    grant_dout,
  output logic [NUM_PORTS-1:0]    resp_valid_dout,
  input  logic [NUM_PORTS-1:0]    resp_ack_din,
  output logic [63:0]             wordC_dout,
  output logic [63:0]             wordD_dout,
  output logic                    busy_dout,
  output logic                    timeout_dout,
  output logic                    eng_start_strobe_dout,
  output logic [63:0]             eng_wordA_dout,
  output logic [63:0]             eng_wordB_dout,
  input  logic                    eng_done_strobe_din,
  input  logic                    eng_active_din,
  input  logic [63:0]             eng_wordC_din,
  input  logic [63:0]             eng_wordD_din
);

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int LIMIT = ROUNDS + 1 + WDOG_SLACK;
  localparam int WW    = $clog2(LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          winner;
  logic [PW-1:0]          pick;
  logic                   found;
  logic                   take;
  logic [63:0]            op_a;
  logic [63:0]            op_b;
  logic [63:0]            res_c;
  logic [63:0]            res_d;
  logic [WW-1:0]          wdog;
  logic                   timeout_q;
  logic                   start_q;
  logic [NUM_PORTS-1:0]   resp_q;

  // Modulo add; NUM_PORTS need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_PORTS)
      s = s - NUM_PORTS;
    return s[PW-1:0];
  endfunction

  function automatic logic [NUM_PORTS-1:0] onehot(
    input logic [PW-1:0] p
  );
    return NUM_PORTS'(1) << p;
  endfunction

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req_din[wrap_inc(rr_ptr, k)]) begin
        pick  = wrap_inc(rr_ptr, k);
        found = 1'b1;
      end
    end
  end

  assign take = (state == IDLE) && reset
             && found && !eng_active_din;

  assign grant_dout = take ? onehot(pick) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res_c     <= '0;
      res_d     <= '0;
      wdog      <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      resp_q    <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            winner  <= pick;
            op_a    <= wordA_din[int'(pick)*64 +: 64];
            op_b    <= wordB_din[int'(pick)*64 +: 64];
            start_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over a coincident watchdog expiry
          if (eng_done_strobe_din) begin
            res_c  <= eng_wordC_din;
            res_d  <= eng_wordD_din;
            resp_q <= onehot(winner);
            state  <= RESPOND;
          end else if (wdog == WW'(LIMIT - 1)) begin
            timeout_q <= 1'b1;
            rr_ptr    <= wrap_inc(winner, 1);
            state     <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESPOND: begin
          if (resp_ack_din[winner]) begin
            resp_q <= '0;
            rr_ptr <= wrap_inc(winner, 1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid_dout       = resp_q;
  assign wordC_dout            = res_c;
  assign wordD_dout            = res_d;
  assign busy_dout             = (state != IDLE);
  assign timeout_dout          = timeout_q;
  assign eng_start_strobe_dout = start_q;
  assign eng_wordA_dout        = op_a;
  assign eng_wordB_dout        = op_b;

endmodule
